// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit byte buffer: launcher state encoding
// and default sizing.
package uart_tx_fifo_pkg;

    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_BUSY_TMO   = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push/status signals and transmitter-side start/data/ready
// handshake of the UART transmit buffer.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  launch_err;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  busy;

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_ready,
        output full, empty, count, overflow, launch_err, tx_start, tx_data, busy
    );

    modport master (
        output wr_en, wr_data, ovf_clr, tx_ready,
        input  full, empty, count, overflow, launch_err, tx_start, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte storage for the transmit buffer: circular memory, pointers, occupancy
// count and a sticky overflow flag for pushes that found no room.
module uart_tx_fifo_sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          wr_data,
    input  logic                pop,
    input  logic                clr,
    output logic [7:0]          rd_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_pop;
    logic                  do_push;

    assign full    = (count == DEPTH[DEPTH_LOG2:0]);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push & ~do_pop)
                count <= count + 1'b1;
            else if (do_pop & ~do_push)
                count <= count - 1'b1;
            if (clr)             overflow <= 1'b0;
            if (push & ~do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues producer bytes and launches them one at a time
// into the transmitter's start/data/ready handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int BUSY_TMO   = DEF_BUSY_TMO
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

    tx_state_e   state;
    logic [TW-1:0] tmo;
    logic [7:0]  fifo_rd;
    logic        fifo_empty;
    logic        pop;

    // Pop decision is taken from the registered count, so it is safe to feed
    // straight back into the FIFO in the same cycle.
    assign pop       = (state == IDLE) & ~fifo_empty & bus.tx_ready;
    assign bus.empty = fifo_empty;

    uart_tx_fifo_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.wr_en),
        .wr_data  (bus.wr_data),
        .pop      (pop),
        .clr      (bus.ovf_clr),
        .rd_data  (fifo_rd),
        .full     (bus.full),
        .empty    (fifo_empty),
        .count    (bus.count),
        .overflow (bus.overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tmo            <= '0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.launch_err <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            if (bus.ovf_clr) bus.launch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.tx_data  <= fifo_rd;
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.tx_start <= 1'b0;
                    tmo          <= '0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.tx_ready) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        // Transmitter never took the byte; drop it and move on.
                        bus.launch_err <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_ready) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: stub transmitter ready model, cycle-level reference
// model of the buffer, and a scoreboard of launched bytes.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 8;
    localparam logic [7:0] HELLO [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
    uart_tx_fifo #(.DEPTH_LOG2(DL), .BUSY_TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb_q [$];
    int mode    = 0;   // 0 normal transmitter, 1 ready held low, 2 ready stuck high
    int low_min = 2;
    int low_max = 5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, launcher as "free / since launch / saw busy".
    initial begin : model
        logic [7:0] mq [$];
        bit free, saw_busy, ovf, lerr, pop;
        int since, sz;
        logic [7:0] txd, pv;
        logic s_rst, s_wr, s_clr, s_rdy;
        logic [7:0] s_d;
        free = 1; saw_busy = 0; ovf = 0; lerr = 0; since = 0; txd = 8'h00;
        forever begin
            @(posedge clk);
            s_rst = rst; s_wr = bus.wr_en; s_d = bus.wr_data;
            s_clr = bus.ovf_clr; s_rdy = bus.tx_ready;
            pop = 0;
            if (s_rst) begin
                mq.delete(); sb_q.delete();
                free = 1; saw_busy = 0; ovf = 0; lerr = 0; since = 0; txd = 8'h00;
            end else begin
                sz = mq.size();
                if (s_clr) begin ovf = 0; lerr = 0; end
                if (free) begin
                    if (sz > 0 && s_rdy) begin
                        pop = 1; pv = mq.pop_front(); txd = pv; sb_q.push_back(pv);
                        free = 0; since = 0; saw_busy = 0;
                    end
                end else begin
                    since++;
                    if (saw_busy) begin
                        if (s_rdy) free = 1;
                    end else if (since >= 2 && !s_rdy) begin
                        saw_busy = 1;
                    end else if (since == TMO + 1) begin
                        lerr = 1; free = 1;
                    end
                end
                if (s_wr) begin
                    if (sz < DEPTH || pop) mq.push_back(s_d);
                    else ovf = 1;
                end
            end
            #1;
            chk("tx_start",   bus.tx_start,   pop);
            chk("tx_data",    bus.tx_data,    txd);
            chk("count",      bus.count,      mq.size());
            chk("full",       bus.full,       mq.size() == DEPTH);
            chk("empty",      bus.empty,      mq.size() == 0);
            chk("overflow",   bus.overflow,   ovf);
            chk("launch_err", bus.launch_err, lerr);
            chk("busy",       bus.busy,       !free);
        end
    end

    // Scoreboard monitor: every start pulse must carry the next expected byte.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.tx_start === 1'b1) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_start: got unexpected start data %0h want none at %0t", bus.tx_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.tx_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got %0h want %0h at %0t", bus.tx_data, e, $time);
                    end
                end
            end
        end
    end

    // Transmitter stub: goes busy a few clocks after a start pulse, then recovers.
    initial begin : stub
        int dly, low;
        bit arm;
        dly = 0; low = 0; arm = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                1: bus.tx_ready = 1'b0;
                2: bus.tx_ready = 1'b1;
                default: begin
                    if (bus.tx_start) begin dly = $urandom_range(0, 2); arm = 1; end
                    if (arm) begin
                        if (dly == 0) begin arm = 0; low = $urandom_range(low_min, low_max); end
                        else dly--;
                    end
                    if (low > 0) begin bus.tx_ready = 1'b0; low--; end
                    else bus.tx_ready = 1'b1;
                end
            endcase
        end
    end

    task automatic push(input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bus.empty && !bus.busy) done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: got not drained want drained within %0d clks", name, budget);
        end
    endtask

    task automatic wait_cond_ready(input string name, input bit want_busy, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (want_busy ? (bus.busy && !bus.tx_ready) : bus.tx_ready) done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: got condition unmet want met within %0d clks", name, budget);
        end
    endtask

    initial begin : main
        int r;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.ovf_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single byte
        push(8'h41);
        wait_drain("t1_drain", 200);

        // string burst
        for (int i = 0; i < 5; i++) push(HELLO[i]);
        wait_drain("t2_drain", 400);

        // overfill with transmitter blocked, clear, then drain
        mode = 1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        pulse_clr();
        mode = 0;
        wait_drain("t3_drain", 1000);

        // full FIFO with a pop and a push landing on the same edge
        mode = 1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        mode = 0;
        wait_cond_ready("t4_ready", 1'b0, 10);
        push(8'hA5);
        wait_drain("t4_drain", 1000);

        // transmitter never goes busy
        mode = 2;
        push(8'h11);
        push(8'h22);
        repeat (30) @(negedge clk);
        pulse_clr();
        mode = 0;
        wait_drain("t5_drain", 200);

        // reset while a frame is on the wire with bytes queued
        low_min = 6; low_max = 9;
        for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
        wait_cond_ready("t6_busy", 1'b1, 20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        low_min = 2; low_max = 5;
        push(8'h5A);
        wait_drain("t6_drain", 200);

        // randomized traffic with changing transmitter behaviour
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                r = $urandom_range(0, 9);
                mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            end
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_data = 8'($urandom);
            bus.ovf_clr = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; mode = 0;
        wait_drain("t7_drain", 3000);
        repeat (3) @(negedge clk);
        chk("sb_leftover", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
